// File: rtl/sddr_phy_cmd_if.sv
// Controller-side command bus and DDR3 pad-side command/address pins of the PHY command stage.
// The slave modport is the PHY; the master modport is the controller plus pad buffers.
interface sddr_phy_cmd_if #(
    parameter int BANK_BITS = 3,
    parameter int ADDR_BITS = 14,
    parameter int RANKS     = 1
);
    localparam int RW = (RANKS > 1) ? $clog2(RANKS) : 1;

    logic                 ctl_cmd_valid_i;
    logic                 ctl_cmd_ready_o;
    logic [RW-1:0]        ctl_rank_i;
    logic                 ctl_ras_n_i;
    logic                 ctl_cas_n_i;
    logic                 ctl_we_n_i;
    logic [BANK_BITS-1:0] ctl_ba_i;
    logic [ADDR_BITS-1:0] ctl_addr_i;
    logic                 ctl_cke_i;
    logic                 ctl_odt_i;
    logic                 ctl_clk_stop_i;
    logic                 phy_ready_o;
    logic                 ck_en_o;
    logic [RANKS-1:0]     ddr3_cs_n_o;
    logic                 ddr3_ras_n_o;
    logic                 ddr3_cas_n_o;
    logic                 ddr3_we_n_o;
    logic [BANK_BITS-1:0] ddr3_ba_o;
    logic [ADDR_BITS-1:0] ddr3_addr_o;
    logic                 ddr3_cke_o;
    logic                 ddr3_odt_o;

    modport slave (
        input  ctl_cmd_valid_i, ctl_rank_i, ctl_ras_n_i, ctl_cas_n_i, ctl_we_n_i,
               ctl_ba_i, ctl_addr_i, ctl_cke_i, ctl_odt_i, ctl_clk_stop_i,
        output ctl_cmd_ready_o, phy_ready_o, ck_en_o, ddr3_cs_n_o, ddr3_ras_n_o,
               ddr3_cas_n_o, ddr3_we_n_o, ddr3_ba_o, ddr3_addr_o, ddr3_cke_o, ddr3_odt_o
    );

    modport master (
        output ctl_cmd_valid_i, ctl_rank_i, ctl_ras_n_i, ctl_cas_n_i, ctl_we_n_i,
               ctl_ba_i, ctl_addr_i, ctl_cke_i, ctl_odt_i, ctl_clk_stop_i,
        input  ctl_cmd_ready_o, phy_ready_o, ck_en_o, ddr3_cs_n_o, ddr3_ras_n_o,
               ddr3_cas_n_o, ddr3_we_n_o, ddr3_ba_o, ddr3_addr_o, ddr3_cke_o, ddr3_odt_o
    );
endinterface

// File: rtl/sddr_phy_cmd.sv
// DDR3 command/address output stage: CK start-up sequencing, valid/ready accept,
// CMD_DELAY-deep registered pin pipeline, multi-rank chip select and clock stop.
module sddr_phy_cmd #(
    parameter int BANK_BITS  = 3,
    parameter int ADDR_BITS  = 14,
    parameter int RANKS      = 1,
    parameter int CMD_DELAY  = 1,
    parameter int CMD_GAP    = 1,
    parameter int CK_STARTUP = 16
)(
    input logic           in_ddr_clock_i,
    input logic           in_phy_reset_i,
    sddr_phy_cmd_if.slave bus
);
    localparam int CW = $clog2(CK_STARTUP);
    localparam int GW = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;

    typedef enum logic [1:0] {ST_HOLD, ST_START, ST_RUN, ST_STOP} state_t;

    typedef struct packed {
        logic [RANKS-1:0]     cs_n;
        logic                 ras_n;
        logic                 cas_n;
        logic                 we_n;
        logic [BANK_BITS-1:0] ba;
        logic [ADDR_BITS-1:0] addr;
        logic                 cke;
        logic                 odt;
    } stage_t;

    localparam stage_t IDLE = '{cs_n: {RANKS{1'b1}}, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1,
                                ba: '0, addr: '0, cke: 1'b0, odt: 1'b0};

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    stage_t        r_pipe [CMD_DELAY];
    stage_t        w_stage0;
    logic          w_ready;
    logic          w_accept;
    logic          w_drained;

    assign w_ready  = (r_state == ST_RUN) && !bus.ctl_clk_stop_i && (r_gap == '0);
    assign w_accept = w_ready && bus.ctl_cmd_valid_i;

    // Clock may only stop once nothing is in flight and CKE is low all the way to the pin.
    always_comb begin
        w_drained = 1'b1;
        for (int i = 0; i < CMD_DELAY; i++) begin
            if ((r_pipe[i].cs_n != {RANKS{1'b1}}) || r_pipe[i].cke) begin
                w_drained = 1'b0;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_HOLD:  w_nextState = ST_START;
            ST_START: if (r_cnt == CW'(CK_STARTUP - 1)) w_nextState = ST_RUN;
            ST_RUN:   if (bus.ctl_clk_stop_i && w_drained && (r_gap == '0)) w_nextState = ST_STOP;
            ST_STOP:  if (!bus.ctl_clk_stop_i) w_nextState = ST_START;
            default:  w_nextState = ST_HOLD;
        endcase
    end

    always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
        if (in_phy_reset_i) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= (r_state == ST_START) ? r_cnt + CW'(1) : '0;
            if (w_accept) begin
                r_gap <= GW'(CMD_GAP - 1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GW'(1);
            end
        end
    end

    // Deselects keep the previous bank/address so idle pins do not toggle.
    always_comb begin
        w_stage0       = r_pipe[0];
        w_stage0.cs_n  = {RANKS{1'b1}};
        w_stage0.ras_n = 1'b1;
        w_stage0.cas_n = 1'b1;
        w_stage0.we_n  = 1'b1;
        if (w_accept && (int'(bus.ctl_rank_i) < RANKS)) begin
            w_stage0.cs_n  = ~(RANKS'(1) << bus.ctl_rank_i);
            w_stage0.ras_n = bus.ctl_ras_n_i;
            w_stage0.cas_n = bus.ctl_cas_n_i;
            w_stage0.we_n  = bus.ctl_we_n_i;
            w_stage0.ba    = bus.ctl_ba_i;
            w_stage0.addr  = bus.ctl_addr_i;
        end
        w_stage0.cke = (r_state == ST_RUN) && bus.ctl_cke_i;
        w_stage0.odt = (r_state == ST_RUN) && bus.ctl_odt_i;
    end

    always_ff @(posedge in_ddr_clock_i or posedge in_phy_reset_i) begin
        if (in_phy_reset_i) begin
            for (int i = 0; i < CMD_DELAY; i++) begin
                r_pipe[i] <= IDLE;
            end
        end else begin
            r_pipe[0] <= w_stage0;
            for (int i = 1; i < CMD_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign bus.ctl_cmd_ready_o = w_ready;
    assign bus.phy_ready_o     = (r_state == ST_RUN);
    assign bus.ck_en_o         = (r_state == ST_START) || (r_state == ST_RUN);
    assign bus.ddr3_cs_n_o     = r_pipe[CMD_DELAY-1].cs_n;
    assign bus.ddr3_ras_n_o    = r_pipe[CMD_DELAY-1].ras_n;
    assign bus.ddr3_cas_n_o    = r_pipe[CMD_DELAY-1].cas_n;
    assign bus.ddr3_we_n_o     = r_pipe[CMD_DELAY-1].we_n;
    assign bus.ddr3_ba_o       = r_pipe[CMD_DELAY-1].ba;
    assign bus.ddr3_addr_o     = r_pipe[CMD_DELAY-1].addr;
    assign bus.ddr3_cke_o      = r_pipe[CMD_DELAY-1].cke;
    assign bus.ddr3_odt_o      = r_pipe[CMD_DELAY-1].odt;
endmodule

// File: tb/tb_sddr_phy_cmd.sv
// Drives two differently parameterised PHY command stages with identical directed and random
// stimulus and compares them each cycle against a timeline model of when each pin value is due.
module tb_sddr_phy_cmd;
    typedef struct packed {
        logic [3:0]  cs;
        logic        ras;
        logic        cas;
        logic        we;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic        cke;
        logic        odt;
    } pin_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        vValid = 1'b0;
    logic [1:0]  vRank  = '0;
    logic        vRas   = 1'b1;
    logic        vCas   = 1'b1;
    logic        vWe    = 1'b1;
    logic [2:0]  vBa    = '0;
    logic [13:0] vAddr  = '0;
    logic        vCke   = 1'b0;
    logic        vOdt   = 1'b0;
    logic        vStop  = 1'b0;

    sddr_phy_cmd_if #(.BANK_BITS(3), .ADDR_BITS(14), .RANKS(3)) ifA ();
    sddr_phy_cmd_if #(.BANK_BITS(3), .ADDR_BITS(14), .RANKS(4)) ifB ();

    assign ifA.ctl_cmd_valid_i = vValid;
    assign ifA.ctl_rank_i      = vRank;
    assign ifA.ctl_ras_n_i     = vRas;
    assign ifA.ctl_cas_n_i     = vCas;
    assign ifA.ctl_we_n_i      = vWe;
    assign ifA.ctl_ba_i        = vBa;
    assign ifA.ctl_addr_i      = vAddr;
    assign ifA.ctl_cke_i       = vCke;
    assign ifA.ctl_odt_i       = vOdt;
    assign ifA.ctl_clk_stop_i  = vStop;
    assign ifB.ctl_cmd_valid_i = vValid;
    assign ifB.ctl_rank_i      = vRank;
    assign ifB.ctl_ras_n_i     = vRas;
    assign ifB.ctl_cas_n_i     = vCas;
    assign ifB.ctl_we_n_i      = vWe;
    assign ifB.ctl_ba_i        = vBa;
    assign ifB.ctl_addr_i      = vAddr;
    assign ifB.ctl_cke_i       = vCke;
    assign ifB.ctl_odt_i       = vOdt;
    assign ifB.ctl_clk_stop_i  = vStop;

    sddr_phy_cmd #(.BANK_BITS(3), .ADDR_BITS(14), .RANKS(3), .CMD_DELAY(3), .CMD_GAP(1),
                   .CK_STARTUP(16)) dutA (
        .in_ddr_clock_i(clock),
        .in_phy_reset_i(reset),
        .bus(ifA.slave)
    );

    sddr_phy_cmd #(.BANK_BITS(3), .ADDR_BITS(14), .RANKS(4), .CMD_DELAY(2), .CMD_GAP(4),
                   .CK_STARTUP(5)) dutB (
        .in_ddr_clock_i(clock),
        .in_phy_reset_i(reset),
        .bus(ifB.slave)
    );

    int passed = 0;
    int total  = 0;

    // sched[d][n] is the pin value the model expects after edge n.
    pin_t sched [2][4096];
    int   edgeNo = 10;
    bit   ckOn [2];
    bit   inStop [2];
    int   warm [2];
    int   gap [2];

    function automatic int pDelay(int d);
        return (d == 0) ? 3 : 2;
    endfunction

    function automatic int pGap(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int pStart(int d);
        return (d == 0) ? 16 : 5;
    endfunction

    function automatic int pRanks(int d);
        return (d == 0) ? 3 : 4;
    endfunction

    function automatic logic [3:0] idleCs(int d);
        return (d == 0) ? 4'b0111 : 4'b1111;
    endfunction

    function automatic pin_t idlePin(int d);
        pin_t p;
        p      = '0;
        p.cs   = idleCs(d);
        p.ras  = 1'b1;
        p.cas  = 1'b1;
        p.we   = 1'b1;
        return p;
    endfunction

    function automatic pin_t obsPins(int d);
        pin_t p;
        if (d == 0) begin
            p = '{cs: {1'b0, ifA.ddr3_cs_n_o}, ras: ifA.ddr3_ras_n_o, cas: ifA.ddr3_cas_n_o,
                  we: ifA.ddr3_we_n_o, ba: ifA.ddr3_ba_o, addr: ifA.ddr3_addr_o,
                  cke: ifA.ddr3_cke_o, odt: ifA.ddr3_odt_o};
        end else begin
            p = '{cs: ifB.ddr3_cs_n_o, ras: ifB.ddr3_ras_n_o, cas: ifB.ddr3_cas_n_o,
                  we: ifB.ddr3_we_n_o, ba: ifB.ddr3_ba_o, addr: ifB.ddr3_addr_o,
                  cke: ifB.ddr3_cke_o, odt: ifB.ddr3_odt_o};
        end
        return p;
    endfunction

    task automatic compare(string tag, int d, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, d, $time, obs, exp);
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            ckOn[d]   = 1'b0;
            inStop[d] = 1'b0;
            warm[d]   = 0;
            gap[d]    = 0;
            for (int j = 0; j < pDelay(d); j++) sched[d][edgeNo-1+j] = idlePin(d);
        end
    endtask

    // One rising edge of the behavioural model, using the inputs held across that edge.
    task automatic modelStep();
        for (int d = 0; d < 2; d++) begin
            int   dl;
            bit   running;
            bit   acc;
            bit   drained;
            pin_t prev;
            pin_t ent;
            dl      = pDelay(d);
            running = ckOn[d] && (warm[d] == 0);
            acc     = running && vValid && !vStop && (gap[d] == 0);
            drained = 1'b1;
            for (int j = 0; j < dl; j++) begin
                if (sched[d][edgeNo-1+j].cs != idleCs(d) || sched[d][edgeNo-1+j].cke) drained = 1'b0;
            end
            prev     = sched[d][edgeNo+dl-2];
            ent      = idlePin(d);
            ent.ba   = prev.ba;
            ent.addr = prev.addr;
            if (acc && int'(vRank) < pRanks(d)) begin
                ent.cs   = idleCs(d) & ~(4'b0001 << vRank);
                ent.ras  = vRas;
                ent.cas  = vCas;
                ent.we   = vWe;
                ent.ba   = vBa;
                ent.addr = vAddr;
            end
            ent.cke = running && vCke;
            ent.odt = running && vOdt;
            sched[d][edgeNo+dl-1] = ent;
            if (!ckOn[d]) begin
                if (!inStop[d] || !vStop) begin
                    ckOn[d]   = 1'b1;
                    warm[d]   = pStart(d);
                    inStop[d] = 1'b0;
                end
            end else if (warm[d] > 0) begin
                warm[d]--;
            end else if (vStop && drained && gap[d] == 0) begin
                ckOn[d]   = 1'b0;
                inStop[d] = 1'b1;
            end
            if (acc) gap[d] = pGap(d) - 1;
            else if (gap[d] > 0) gap[d]--;
        end
        edgeNo++;
    endtask

    task automatic checkOutput();
        for (int d = 0; d < 2; d++) begin
            bit   running;
            pin_t exp;
            running = ckOn[d] && (warm[d] == 0);
            exp     = sched[d][edgeNo-1];
            compare("ck_en", d, 32'((d == 0) ? ifA.ck_en_o : ifB.ck_en_o), 32'(ckOn[d]));
            compare("phy_ready", d, 32'((d == 0) ? ifA.phy_ready_o : ifB.phy_ready_o), 32'(running));
            compare("cmd_ready", d, 32'((d == 0) ? ifA.ctl_cmd_ready_o : ifB.ctl_cmd_ready_o),
                    32'(running && !vStop && gap[d] == 0));
            compare("pins", d, 32'(obsPins(d)), 32'(exp));
        end
    endtask

    task automatic applyStimulus(int n);
        repeat (n) begin
            #1 checkOutput();
            @(posedge clock);
            if (!reset) modelStep();
            @(negedge clock);
        end
    endtask

    task automatic setCmd(bit valid, int rank, bit ras, bit cas, bit we, int ba, int addr);
        vValid = valid;
        vRank  = 2'(rank);
        vRas   = ras;
        vCas   = cas;
        vWe    = we;
        vBa    = 3'(ba);
        vAddr  = 14'(addr);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        modelReset();
        vCke = 1'b1;
        applyStimulus(2);
        reset = 1'b0;

        // Start-up with CKE requested high: pins must keep CKE low until running.
        applyStimulus(20);
        compare("startup_ready", 0, 32'(ifA.phy_ready_o), 32'd1);

        // ACT then WRITE back to back.
        setCmd(1, 0, 0, 1, 1, 5, 'h1A2B);
        applyStimulus(1);
        setCmd(1, 0, 1, 0, 0, 5, 'h0040);
        applyStimulus(1);
        setCmd(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(5);

        // Valid held high: gap-limited accepts on the CMD_GAP=4 instance.
        for (int i = 0; i < 12; i++) begin
            setCmd(1, i % 3, i[0], i[1], i[2], i, 'h100 + i);
            applyStimulus(1);
        end

        // Rank 2, then rank 3 (out of range for the 3-rank instance).
        setCmd(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(4);
        setCmd(1, 2, 0, 1, 0, 3, 'h0777);
        applyStimulus(1);
        setCmd(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(4);
        setCmd(1, 3, 0, 1, 0, 6, 'h0555);
        applyStimulus(1);
        setCmd(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(4);

        // Clock stop after draining CKE, then restart.
        vCke = 1'b0;
        applyStimulus(6);
        vStop = 1'b1;
        applyStimulus(6);
        compare("stopped_ck_en", 0, 32'(ifA.ck_en_o), 32'd0);
        compare("stopped_ck_en", 1, 32'(ifB.ck_en_o), 32'd0);
        vStop = 1'b0;
        vCke  = 1'b1;
        applyStimulus(20);

        // Stop request while CKE is high must be ignored.
        vStop = 1'b1;
        applyStimulus(6);
        compare("stop_with_cke", 0, 32'(ifA.phy_ready_o), 32'd1);
        vStop = 1'b0;
        applyStimulus(2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            setCmd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 16383));
            vCke  = (i % 100) < 70 ? ($urandom_range(0, 7) != 0) : 1'b0;
            vOdt  = $urandom_range(0, 1);
            vStop = ($urandom_range(0, 9) == 0);
            applyStimulus(1);
        end

        // Reset mid-burst: in-flight commands must never reach the pins.
        vStop = 1'b0;
        vCke  = 1'b1;
        applyStimulus(20);
        setCmd(1, 1, 0, 0, 1, 2, 'h2222);
        applyStimulus(2);
        reset = 1'b1;
        modelReset();
        #1 checkOutput();
        applyStimulus(2);
        reset = 1'b0;
        setCmd(0, 0, 1, 1, 1, 0, 0);
        applyStimulus(25);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
